// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register bank.
//   resp_t     : AXI response encoding (OKAY/EXOKAY/SLVERR/DECERR)
//   reg_mode_t : per-register access mode (RW, RO, W1C)
//   reg_mode() : derives a register's mode from its RO and W1C mask bits
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        MODE_RW  = 2'd0,
        MODE_RO  = 2'd1,
        MODE_W1C = 2'd2
    } reg_mode_t;

    // RO wins when a register is flagged in both masks.
    function automatic reg_mode_t reg_mode(input logic ro_bit, input logic w1c_bit);
        if (ro_bit) return MODE_RO;
        if (w1c_bit) return MODE_W1C;
        return MODE_RW;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
//   master modport : drives AW/W/AR payload+valid, BREADY, RREADY
//   slave  modport : drives AWREADY, WREADY, B response, ARREADY, R response
interface axi_lite_reg_bank_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decode for the register bank.
//   addr_i : byte address from AW or AR channel
//   idx_o  : register index (meaningful only when resp_o is OKAY)
//   resp_o : DECERR outside the window, SLVERR if not word aligned, else OKAY
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                REG_NUMS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                IDX_W     = (REG_NUMS > 1) ? $clog2(REG_NUMS) : 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output resp_t             resp_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(REG_NUMS * BYTES);

    logic [ADDR_W-1:0] off;
    logic              below;
    logic              beyond;
    logic              unaligned;

    assign off       = addr_i - BASE_ADDR;
    assign below     = addr_i < BASE_ADDR;
    // Extra MSB keeps the compare exact when the window reaches the top of the space.
    assign beyond    = {1'b0, off} >= SPAN;
    assign unaligned = |off[LSB-1:0];
    assign idx_o     = off[LSB +: IDX_W];

    always_comb begin
        if (below || beyond) resp_o = RESP_DECERR;
        else if (unaligned)  resp_o = RESP_SLVERR;
        else                 resp_o = RESP_OKAY;
    end
endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C access.
//   S_AXI_ACLK, S_AXI_ARESET : clock, async active-high reset
//   s_axi    : AXI4-Lite slave bus (AW/W/B/AR/R)
//   reg_q    : flat register contents, RO slots mirror ro_in
//   ro_in    : hardware values for RO registers
//   w1c_set  : per-bit set pulses for W1C registers
//   wr_pulse : one-cycle strobe per register on a successful write
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_REG_NUMS         = 16,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter logic [C_REG_NUMS-1:0]         C_RO_MASK          = '0,
    parameter logic [C_REG_NUMS-1:0]         C_W1C_MASK         = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    axi_lite_reg_bank_if.slave                       s_axi,
    output logic [C_REG_NUMS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    input  logic [C_REG_NUMS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    input  logic [C_REG_NUMS*C_S_AXI_DATA_WIDTH-1:0] w1c_set,
    output logic [C_REG_NUMS-1:0]                    wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int IDX_W = (C_REG_NUMS > 1) ? $clog2(C_REG_NUMS) : 1;

    // Readies stay low until the first edge after reset release.
    logic                  rst_done_q;
    logic                  aw_held_q, aw_held_d;
    logic [AW-1:0]         awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [BYTES-1:0]      wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;
    logic [C_REG_NUMS-1:0] wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    resp_t                 rresp_q, rresp_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic             awready, wready, arready;
    logic             aw_hs, w_hs, ar_hs, commit, wr_en;
    logic [AW-1:0]    cur_awaddr;
    logic [DW-1:0]    cur_wdata;
    logic [BYTES-1:0] cur_wstrb;
    logic [IDX_W-1:0] w_idx, r_idx;
    resp_t            w_dec_resp, w_resp, r_resp;
    logic [DW-1:0]    reg_arr  [C_REG_NUMS];
    reg_mode_t        mode_arr [C_REG_NUMS];

    assign awready = rst_done_q && !aw_held_q && !bvalid_q;
    assign wready  = rst_done_q && !w_held_q && !bvalid_q;
    assign arready = rst_done_q && !rvalid_q;

    assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
    assign w_hs   = s_axi.S_AXI_WVALID && wready;
    assign ar_hs  = s_axi.S_AXI_ARVALID && arready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // A channel that handshakes this cycle bypasses its holding register.
    assign cur_awaddr = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
    assign cur_wdata  = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
    assign cur_wstrb  = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;

    axi_lite_addr_decode #(
        .ADDR_W(AW), .DATA_W(DW), .REG_NUMS(C_REG_NUMS),
        .BASE_ADDR(C_BASE_ADDR), .IDX_W(IDX_W)
    ) u_wr_decode (
        .addr_i(cur_awaddr), .idx_o(w_idx), .resp_o(w_dec_resp)
    );

    axi_lite_addr_decode #(
        .ADDR_W(AW), .DATA_W(DW), .REG_NUMS(C_REG_NUMS),
        .BASE_ADDR(C_BASE_ADDR), .IDX_W(IDX_W)
    ) u_rd_decode (
        .addr_i(s_axi.S_AXI_ARADDR), .idx_o(r_idx), .resp_o(r_resp)
    );

    assign w_resp = (w_dec_resp == RESP_OKAY && mode_arr[w_idx] == MODE_RO) ? RESP_SLVERR
                                                                          : w_dec_resp;
    assign wr_en  = commit && (w_resp == RESP_OKAY);

    for (genvar gi = 0; gi < C_REG_NUMS; gi++) begin : g_reg
        localparam reg_mode_t MODE = reg_mode(C_RO_MASK[gi], C_W1C_MASK[gi]);

        assign mode_arr[gi]          = MODE;
        assign reg_q[gi*DW +: DW]    = reg_arr[gi];

        if (MODE == MODE_RO) begin : g_ro
            assign reg_arr[gi] = ro_in[gi*DW +: DW];
        end else begin : g_store
            logic [DW-1:0] val_q, val_d;

            // W1C: software clears strobed 1-bits first, then hardware sets
            // are ORed on top so a same-cycle set survives the clear.
            always_comb begin
                val_d = val_q;
                if (wr_en && (w_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (cur_wstrb[b]) begin
                            if (MODE == MODE_W1C) val_d[b*8 +: 8] = val_q[b*8 +: 8] & ~cur_wdata[b*8 +: 8];
                            else                  val_d[b*8 +: 8] = cur_wdata[b*8 +: 8];
                        end
                    end
                end
                if (MODE == MODE_W1C) val_d = val_d | w1c_set[gi*DW +: DW];
            end

            always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
                if (S_AXI_ARESET) val_q <= '0;
                else              val_q <= val_d;
            end

            assign reg_arr[gi] = val_q;
        end
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_resp;
            if (wr_en) wr_pulse_d[w_idx] = 1'b1;
        end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Sampled from the pre-commit register values, so a same-cycle
        // write to the same register is not visible to this read.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = r_resp;
            rdata_d  = (r_resp == RESP_OKAY) ? reg_arr[r_idx] : '0;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rst_done_q <= 1'b0;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign wr_pulse            = wr_pulse_q;

    // PROT is ignored; ro_in / w1c_set slots of other register kinds are don't-care.
    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, ro_in, w1c_set};
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
module tb_axi_lite_reg_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] reg_q;
    logic [511:0] ro_in = '0;
    logic [511:0] w1c_set = '0;
    logic [15:0]  wr_pulse;

    int checks = 0;
    int failures = 0;

    logic [1:0]   wresp;
    logic [15:0]  wpulse;
    int           pcnt;
    bit           wstable;
    int           wlat;
    logic [31:0]  rdat;
    logic [1:0]   rresp;
    bit           rstable;
    int           rlat;
    logic [511:0] snap;

    axi_lite_reg_bank_if #(.DW(32), .AW(32)) bus ();

    axi_lite_reg_bank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .C_REG_NUMS(16),
        .C_BASE_ADDR(32'h0), .C_RO_MASK(16'h0010), .C_W1C_MASK(16'h0020)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
        .reg_q(reg_q), .ro_in(ro_in), .w1c_set(w1c_set), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s got=no_handshake exp=handshake", what);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int order, input int bhold,
                             output logic [1:0] resp, output logic [15:0] pulse, output int pulse_cnt,
                             output bit stable, output int lat);
        int n;
        pulse_cnt = 0; stable = 1'b1; lat = 0; resp = 2'bxx; pulse = '0;
        if (order != 2) begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
        if (order != 1) begin bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1; end
        n = 0;
        while (!((bus.S_AXI_AWREADY || !bus.S_AXI_AWVALID) && (bus.S_AXI_WREADY || !bus.S_AXI_WVALID)) && n < 20) begin
            tick(); n++;
        end
        if (n >= 20) timeout_fail("wr_first");
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        if (order != 0) begin
            tick();
            if (order == 2) begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
            else begin bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1; end
            n = 0;
            while (!(bus.S_AXI_AWREADY || bus.S_AXI_WREADY) && n < 20) begin tick(); n++; end
            if (n >= 20) timeout_fail("wr_second");
            tick();
            bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        end
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin
            if (wr_pulse != 0) pulse_cnt++;
            tick(); n++;
        end
        lat = n;
        if (!bus.S_AXI_BVALID) timeout_fail("bvalid");
        resp = bus.S_AXI_BRESP; pulse = wr_pulse;
        for (int i = 0; i < bhold; i++) begin
            if (wr_pulse != 0) pulse_cnt++;
            tick();
            if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== resp || bus.S_AXI_AWREADY || bus.S_AXI_WREADY)
                stable = 1'b0;
        end
        if (wr_pulse != 0) pulse_cnt++;
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (wr_pulse != 0) pulse_cnt++;
            tick();
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output bit stable, output int lat);
        int n;
        stable = 1'b1; data = 'x; resp = 2'bxx;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
        if (n >= 20) timeout_fail("arready");
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin tick(); n++; end
        lat = n;
        if (!bus.S_AXI_RVALID) timeout_fail("rvalid");
        data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
        for (int i = 0; i < rhold; i++) begin
            tick();
            if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== data || bus.S_AXI_RRESP !== resp || bus.S_AXI_ARREADY)
                stable = 1'b0;
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hs got=%b exp=00000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                     bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        checks++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, wr_pulse} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, wr_pulse);
        end
        checks++;
        if (reg_q !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", reg_q); end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL post_reset_ready got=%b exp=111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
    endtask

    task automatic test_write_aw_first();
        axi_write(32'h08, 32'haa000055, 4'b1001, 1, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b00) begin failures++; $display("FAIL awfirst_bresp got=%b exp=00", wresp); end
        checks++;
        if (wlat !== 0) begin failures++; $display("FAIL awfirst_blat got=%0d exp=0", wlat); end
        checks++;
        if (wpulse !== 16'h0004) begin failures++; $display("FAIL awfirst_pulse got=%h exp=0004", wpulse); end
        checks++;
        if (pcnt !== 1) begin failures++; $display("FAIL awfirst_pulse_cycles got=%0d exp=1", pcnt); end
        checks++;
        if (reg_q[2*32 +: 32] !== 32'haa000055) begin
            failures++; $display("FAIL awfirst_reg_q got=%h exp=aa000055", reg_q[2*32 +: 32]);
        end
        axi_read(32'h08, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'haa000055 || rresp !== 2'b00) begin
            failures++; $display("FAIL awfirst_read got=%h/%b exp=aa000055/00", rdat, rresp);
        end
        checks++;
        if (rlat !== 0) begin failures++; $display("FAIL read_lat got=%0d exp=0", rlat); end
    endtask

    task automatic test_write_w_first();
        axi_write(32'h20, 32'hffffffff, 4'hf, 0, 0, wresp, wpulse, pcnt, wstable, wlat);
        axi_write(32'h20, 32'h00001155, 4'b0011, 2, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b00 || wpulse !== 16'h0100) begin
            failures++; $display("FAIL wfirst_resp got=%b/%h exp=00/0100", wresp, wpulse);
        end
        axi_read(32'h20, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'hffff1155) begin failures++; $display("FAIL wfirst_read got=%h exp=ffff1155", rdat); end
    endtask

    task automatic test_errors();
        axi_write(32'h00, 32'h12345678, 4'hf, 0, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b00 || wpulse !== 16'h0001) begin
            failures++; $display("FAIL reg0_write got=%b/%h exp=00/0001", wresp, wpulse);
        end
        snap = reg_q;
        axi_write(32'h0100_0000, 32'hffffffff, 4'hf, 0, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b11 || pcnt !== 0) begin
            failures++; $display("FAIL oor_write got=%b/%0d exp=11/0", wresp, pcnt);
        end
        axi_write(32'h01, 32'hffffffff, 4'hf, 1, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b10 || pcnt !== 0) begin
            failures++; $display("FAIL unaligned_write got=%b/%0d exp=10/0", wresp, pcnt);
        end
        axi_write(32'h40, 32'hffffffff, 4'hf, 0, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b11) begin failures++; $display("FAIL edge_write got=%b exp=11", wresp); end
        checks++;
        if (reg_q !== snap) begin failures++; $display("FAIL err_no_change got=%h exp=%h", reg_q[255:0], snap[255:0]); end
        axi_read(32'h0100_0000, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0 || rresp !== 2'b11) begin
            failures++; $display("FAIL oor_read got=%h/%b exp=00000000/11", rdat, rresp);
        end
        axi_read(32'h01, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0 || rresp !== 2'b10) begin
            failures++; $display("FAIL unaligned_read got=%h/%b exp=00000000/10", rdat, rresp);
        end
        axi_read(32'h40, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rresp !== 2'b11) begin failures++; $display("FAIL edge_read_40 got=%b exp=11", rresp); end
        axi_read(32'h3c, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0 || rresp !== 2'b00) begin
            failures++; $display("FAIL edge_read_3c got=%h/%b exp=00000000/00", rdat, rresp);
        end
    endtask

    task automatic test_ro();
        ro_in[4*32 +: 32] = 32'hdeadbeef;
        axi_write(32'h10, 32'h0, 4'hf, 0, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b10 || pcnt !== 0) begin
            failures++; $display("FAIL ro_write got=%b/%0d exp=10/0", wresp, pcnt);
        end
        axi_read(32'h10, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'hdeadbeef || rresp !== 2'b00) begin
            failures++; $display("FAIL ro_read got=%h/%b exp=deadbeef/00", rdat, rresp);
        end
        checks++;
        if (reg_q[4*32 +: 32] !== 32'hdeadbeef) begin
            failures++; $display("FAIL ro_reg_q got=%h exp=deadbeef", reg_q[4*32 +: 32]);
        end
    endtask

    task automatic test_w1c();
        w1c_set[5*32 +: 32] = 32'h0000000f;
        tick();
        w1c_set = '0;
        axi_read(32'h14, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0000000f) begin failures++; $display("FAIL w1c_set got=%h exp=0000000f", rdat); end
        axi_write(32'h14, 32'h00000005, 4'hf, 1, 0, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wresp !== 2'b00 || wpulse !== 16'h0020) begin
            failures++; $display("FAIL w1c_write got=%b/%h exp=00/0020", wresp, wpulse);
        end
        axi_read(32'h14, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0000000a) begin failures++; $display("FAIL w1c_clear got=%h exp=0000000a", rdat); end
        bus.S_AXI_AWADDR = 32'h14; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hf; bus.S_AXI_WVALID = 1'b1;
        w1c_set[5*32 +: 32] = 32'h1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b11) begin
            failures++; $display("FAIL w1c_race_ready got=%b exp=11", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; w1c_set = '0;
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            failures++; $display("FAIL w1c_race_b got=%b/%b exp=1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
        end
        bus.S_AXI_BREADY = 1'b1; tick(); bus.S_AXI_BREADY = 1'b0;
        axi_read(32'h14, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h0000000b) begin failures++; $display("FAIL w1c_set_wins got=%h exp=0000000b", rdat); end
    endtask

    task automatic test_back_to_back();
        axi_write(32'h18, 32'h13579bdf, 4'hf, 0, 10, wresp, wpulse, pcnt, wstable, wlat);
        checks++;
        if (wstable !== 1'b1 || wresp !== 2'b00 || pcnt !== 1) begin
            failures++; $display("FAIL bhold got=%b/%b/%0d exp=1/00/1", wstable, wresp, pcnt);
        end
        axi_read(32'h18, 10, rdat, rresp, rstable, rlat);
        checks++;
        if (rstable !== 1'b1 || rdat !== 32'h13579bdf) begin
            failures++; $display("FAIL rhold got=%b/%h exp=1/13579bdf", rstable, rdat);
        end
        bus.S_AXI_ARADDR = 32'h18; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_AWADDR = 32'h18; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h2468ace0; bus.S_AXI_WSTRB = 4'hf; bus.S_AXI_WVALID = 1'b1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            failures++; $display("FAIL rw_race_ready got=%b exp=111",
                                 {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        tick();
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h13579bdf || bus.S_AXI_BVALID !== 1'b1) begin
            failures++; $display("FAIL rw_race_old got=%b/%h/%b exp=1/13579bdf/1",
                                 bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID);
        end
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        axi_read(32'h18, 0, rdat, rresp, rstable, rlat);
        checks++;
        if (rdat !== 32'h2468ace0) begin failures++; $display("FAIL rw_race_new got=%h exp=2468ace0", rdat); end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  stray;
        bus.S_AXI_AWADDR = 32'h1c; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_ARADDR = 32'h08; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1) begin failures++; $display("FAIL mid_rvalid got=%b exp=1", bus.S_AXI_RVALID); end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID,
             bus.S_AXI_RDATA, wr_pulse} !== '0) begin
            failures++; $display("FAIL mid_reset_out got=%b/%b/%b/%b/%b/%h/%h exp=0", bus.S_AXI_AWREADY,
                                 bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID,
                                 bus.S_AXI_RDATA, wr_pulse);
        end
        checks++;
        if (reg_q[2*32 +: 32] !== 32'h0 || reg_q[5*32 +: 32] !== 32'h0) begin
            failures++; $display("FAIL mid_reset_regs got=%h/%h exp=0/0", reg_q[2*32 +: 32], reg_q[5*32 +: 32]);
        end
        tick(); tick();
        rst = 1'b0;
        bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hf; bus.S_AXI_WVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_WREADY && n < 20) begin tick(); n++; end
        if (n >= 20) timeout_fail("mid_wready");
        tick();
        bus.S_AXI_WVALID = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.S_AXI_BVALID || bus.S_AXI_RVALID || wr_pulse != 0) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray !== 1'b0) begin failures++; $display("FAIL mid_stray_resp got=%b exp=0", stray); end
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        test_reset();
        test_write_aw_first();
        test_write_w_first();
        test_errors();
        test_ro();
        test_w1c();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
